// File: rtl/voice_allocator_if.sv
// Event handshake between the note decoder (master) and the voice allocator (slave).
//   ev_valid : event offered by the master
//   ev_ready : allocator can accept an event
//   ev_on    : 1 = note-on, 0 = note-off
//   ev_note  : note index
interface voice_allocator_if #(
  parameter int unsigned NOTE_W = 5
) ();
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on events to voice slots (retrigger,
// then free, then steal least-recently-allocated) and runs a linear release ramp.
//   clk, reset_n  : clock, asynchronous active-low reset
//   ev            : event handshake (slave modport)
//   voice_note    : per-voice note, voice i at [i*NOTE_W +: NOTE_W]
//   voice_volume  : per-voice volume, voice i at [i*VOL_W +: VOL_W]
//   voice_gate    : per-voice key-down flag
//   steal_pulse   : one-cycle pulse after a sounding voice was stolen
module voice_allocator #(
  parameter int unsigned VOICES       = 8,
  parameter int unsigned NOTE_W       = 5,
  parameter int unsigned VOL_W        = 21,
  parameter int unsigned VOL_MAX      = 1 << 20,
  parameter int unsigned RELEASE_STEP = 1 << 14,
  parameter int unsigned RELEASE_DIV  = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  voice_allocator_if.slave          ev,
  output logic [VOICES*NOTE_W-1:0]  voice_note,
  output logic [VOICES*VOL_W-1:0]   voice_volume,
  output logic [VOICES-1:0]         voice_gate,
  output logic                      steal_pulse
);

  localparam int unsigned IDX_W   = $clog2(VOICES);
  localparam int unsigned PRESC_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
  localparam logic [VOL_W-1:0]   VOL_MAX_V  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]   STEP_V     = VOL_W'(RELEASE_STEP);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RELEASE_DIV - 1);
  localparam logic [IDX_W-1:0]   RANK_LAST  = IDX_W'(VOICES - 1);

  typedef enum logic [0:0] {S_IDLE, S_COMMIT} fsm_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

  fsm_t              fsm_q;
  logic              ready_q;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [PRESC_W-1:0] presc_q;
  logic              steal_q;

  vstate_t           vst_q   [VOICES];
  logic [NOTE_W-1:0] vnote_q [VOICES];
  logic [VOL_W-1:0]  vol_q   [VOICES];
  logic [IDX_W-1:0]  rank_q  [VOICES];
  logic [VOICES-1:0] gate_q;

  logic              tick;
  logic              hit_found, free_found, do_steal;
  logic [IDX_W-1:0]  hit_idx, free_idx, lru_idx, tgt_idx, tgt_rank;
  logic              commit_on, commit_off;

  assign tick       = (presc_q == PRESC_LAST);
  assign commit_on  = (fsm_q == S_COMMIT) && ev_on_q;
  assign commit_off = (fsm_q == S_COMMIT) && !ev_on_q;

  // Note-on target: lowest-index matching sounding voice, else lowest free, else LRU.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lru_idx    = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!hit_found && vst_q[i] != V_FREE && vnote_q[i] == ev_note_q) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!free_found && vst_q[i] == V_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rank_q[i] == RANK_LAST) lru_idx = IDX_W'(i);
    end
    do_steal = !hit_found && !free_found;
    tgt_idx  = hit_found ? hit_idx : (free_found ? free_idx : lru_idx);
    tgt_rank = rank_q[tgt_idx];
  end

  // Control FSM, prescaler and per-voice state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= S_IDLE;
      ready_q   <= 1'b1;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      presc_q   <= '0;
      steal_q   <= 1'b0;
      gate_q    <= '0;
      for (int i = 0; i < VOICES; i++) begin
        vst_q[i]   <= V_FREE;
        vnote_q[i] <= '0;
        vol_q[i]   <= '0;
        rank_q[i]  <= IDX_W'(i);
      end
    end else begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      steal_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (ev.ev_valid) begin
            ev_on_q   <= ev.ev_on;
            ev_note_q <= ev.ev_note;
            fsm_q     <= S_COMMIT;
            ready_q   <= 1'b0;
          end
        end
        S_COMMIT: begin
          fsm_q   <= S_IDLE;
          ready_q <= 1'b1;
          steal_q <= ev_on_q && do_steal;
        end
        default: fsm_q <= S_IDLE;
      endcase
      for (int i = 0; i < VOICES; i++) begin
        if (commit_on && tgt_idx == IDX_W'(i)) begin
          // Allocation overrides any coincident release tick on this voice.
          vnote_q[i] <= ev_note_q;
          vol_q[i]   <= VOL_MAX_V;
          vst_q[i]   <= V_HELD;
          gate_q[i]  <= 1'b1;
          rank_q[i]  <= '0;
        end else begin
          if (commit_on && rank_q[i] < tgt_rank) rank_q[i] <= rank_q[i] + IDX_W'(1);
          if (commit_off && vst_q[i] == V_HELD && vnote_q[i] == ev_note_q) begin
            vst_q[i]  <= V_REL;
            gate_q[i] <= 1'b0;
          end else if (tick && vst_q[i] == V_REL) begin
            if (vol_q[i] <= STEP_V) begin
              vol_q[i] <= '0;
              vst_q[i] <= V_FREE;
            end else begin
              vol_q[i] <= vol_q[i] - STEP_V;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign voice_note[g*NOTE_W +: NOTE_W] = vnote_q[g];
    assign voice_volume[g*VOL_W +: VOL_W] = vol_q[g];
  end

  assign voice_gate  = gate_q;
  assign steal_pulse = steal_q;
  assign ev.ev_ready = ready_q;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the PS/2 note decoder and the oscillator/mixer bank. It takes note-on/note-off events through a valid/ready handshake and assigns each note-on to one of VOICES oscillator slots. Allocation prefers a free voice, otherwise steals the least-recently-allocated one. Note-offs start a linear release ramp on the matching voices, so each voice's volume decays to zero before the slot is reused.

## Interface
- VOICES, 8: number of voice slots; power of two, 2..16
- NOTE_W, 5: note-index width; every value is a valid note
- VOL_W, 21: volume width, unsigned
- VOL_MAX, 1<<20: volume applied at note-on
- RELEASE_STEP, 1<<14: decrement applied per release tick
- RELEASE_DIV, 1024: clock cycles per release tick, ≥1
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event offered
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note index
- voice_note  out  VOICES*NOTE_W  voice i note in bits [i*NOTE_W +: NOTE_W]
- voice_volume  out  VOICES*VOL_W  voice i volume in bits [i*VOL_W +: VOL_W]
- voice_gate  out  VOICES  1 = voice held (key down)
- steal_pulse  out  1  one-cycle pulse when a sounding voice was stolen

## Operation
- Per-voice state: FREE (volume 0), HELD, RELEASE.
- Per-voice LRU rank 0..VOICES-1 forms a permutation. Rank 0 is the most recently allocated voice. Reset ranks: voice i = i.
- FSM states: IDLE and COMMIT.
  - In IDLE, ev_ready=1. ev_valid&ev_ready latches ev_on/ev_note and moves to COMMIT.
  - In COMMIT, ev_ready=0. The event is applied and the FSM returns to IDLE.
- Note-on target selection in COMMIT, first match wins:
  - any voice in HELD or RELEASE with voice_note==ev_note (lowest index): retrigger;
  - lowest-index FREE voice;
  - voice with rank VOICES-1: steal, and steal_pulse=1.
- Note-on applied to the target voice:
  - note←ev_note, volume←VOL_MAX, state←HELD, gate=1;
  - target rank←0;
  - every voice whose rank was below the target's old rank gets rank+1;
  - all other ranks are unchanged.
- Note-off: every HELD voice with matching note goes to RELEASE, gate=0. Ranks are unchanged. No match means no state change.
- Release ramp:
  - a prescaler counts 0..RELEASE_DIV-1 and asserts tick on the wrap cycle;
  - on tick, each RELEASE voice sets volume←max(volume-RELEASE_STEP, 0);
  - a voice reaching 0 becomes FREE. Its note output holds its last value.
- The prescaler runs free and is unaffected by events.

## Timing
- Reset values:
  - ev_ready=1, steal_pulse=0;
  - all voice_note=0, voice_volume=0, voice_gate=0;
  - all voices FREE, prescaler=0, FSM=IDLE.
- Reset is asynchronous and may be asserted mid-event. A latched event is discarded and no voice is updated.
- Event latency: accepted at edge N, voice outputs update at edge N+1, ev_ready is high again after edge N+1.
- Throughput: one event per 2 cycles.
- steal_pulse is high for exactly the cycle after the COMMIT edge. It is registered alongside the voice update.
- A release tick and a COMMIT targeting the same voice in the same cycle: the COMMIT wins (volume=VOL_MAX, no decrement). Other voices still take the tick.
- A release tick coinciding with a note-off: the newly released voice does not decrement on that edge.
- Volume arithmetic: unsigned VOL_W, saturating at 0, never wraps.
- All outputs are registered with no combinational path from ev_* to voice_*. ev_ready depends only on FSM state.

## Test plan
All scenarios use VOICES=8 and RELEASE_DIV=4 unless stated.
- Reset then 8 note-ons, notes 1..8 -> voices 0..7 get notes 1..8, all volume 0x100000, gate=0xFF, steal_pulse never high.
- A 9th note-on (note 9) with all 8 voices held -> voice 0 stolen: voice_note[0]=9, steal_pulse high for one cycle. A 10th note-on (note 10) -> voice 1 stolen.
- Note-on 3 then note-off 3 -> gate[0]=0. Volume falls by 0x4000 every 4 cycles and reaches 0 after 64 ticks (256 cycles ±4), then the voice is FREE. The next note-on reuses voice 0.
- Note-on 5, note-off 5, then note-on 5 again after 10 ticks -> same voice retriggered, volume back to 0x100000, gate=1, no steal.
- Note-off 7 with no voice holding 7 -> no output change. ev_valid held high for 6 cycles -> exactly 3 events accepted, ev_ready toggles 1,0,1,0.
- reset_n low asynchronously in the COMMIT cycle of a note-on -> all outputs reach reset values immediately. After release, voice 0 is the first allocated.
